// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline control blocks.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load still in EX.
module load_use_detect
  import rv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  // x0 is hardwired to zero, so a load "into" it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != X0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline register enable/flush sequencer: load-use bubbles, branch flushes and
// data-memory wait with timeout. All strobes are Mealy (same-cycle).
module pipe_stall_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] LB_INIT  = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] FC_INIT  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  state_t           ret_state_reg, ret_state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ret_cnt_reg, ret_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             timeout_err_reg;
  logic             timeout_set;
  logic             load_use;
  logic             mem_wait;
  logic [3:0]       en_c;   // {pc, ifid, idex, exmem}
  logic [1:0]       fl_c;   // {ifid_flush, idex_flush}

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_wait = mem_req && !mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RUN;
      ret_state_reg   <= RUN;
      cnt_reg         <= '0;
      ret_cnt_reg     <= '0;
      stall_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_state_reg   <= ret_state_next;
      cnt_reg         <= cnt_next;
      ret_cnt_reg     <= ret_cnt_next;
      timeout_err_reg <= timeout_err_reg | timeout_set;
      if (!pc_en && (stall_cnt_reg != CNT_SAT))
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    cnt_next       = cnt_reg;
    ret_cnt_next   = ret_cnt_reg;
    timeout_set    = 1'b0;
    en_c           = 4'b1111;
    fl_c           = 2'b00;
    case (state_reg)
      MEM_WAIT: begin
        en_c = 4'b0000;
        if (mem_ready) begin
          // A bubble/flush run whose count already expired has nothing left to do.
          if ((ret_state_reg != RUN) && (ret_cnt_reg == '0))
            state_next = RUN;
          else
            state_next = ret_state_reg;
          cnt_next = ret_cnt_reg;
        end else if (cnt_reg == TMO) begin
          timeout_set = 1'b1;
          state_next  = RUN;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        if (mem_wait) begin
          en_c           = 4'b0000;
          ret_state_next = state_reg;
          ret_cnt_next   = cnt_reg;
          state_next     = MEM_WAIT;
          cnt_next       = CNT_ONE;
        end else if (ex_branch_taken) begin
          fl_c       = 2'b11;
          state_next = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          cnt_next   = (FLUSH_CYCLES > 1) ? FC_INIT : '0;
        end else if (state_reg == LOAD_STALL) begin
          en_c       = 4'b0011;
          fl_c       = 2'b01;
          state_next = (cnt_reg <= CNT_ONE) ? RUN : LOAD_STALL;
          cnt_next   = (cnt_reg <= CNT_ONE) ? '0 : cnt_reg - CNT_ONE;
        end else if (state_reg == FLUSH) begin
          fl_c       = 2'b10;
          state_next = (cnt_reg <= CNT_ONE) ? RUN : FLUSH;
          cnt_next   = (cnt_reg <= CNT_ONE) ? '0 : cnt_reg - CNT_ONE;
        end else if (load_use) begin
          en_c       = 4'b0011;
          fl_c       = 2'b01;
          state_next = (LOAD_BUBBLES > 1) ? LOAD_STALL : RUN;
          cnt_next   = (LOAD_BUBBLES > 1) ? LB_INIT : '0;
        end
      end
    endcase
  end

  // Everything is held low while reset is asserted, independent of the clock.
  assign pc_en       = en_c[3] & ~rst;
  assign ifid_en     = en_c[2] & ~rst;
  assign idex_en     = en_c[1] & ~rst;
  assign exmem_en    = en_c[0] & ~rst;
  assign ifid_flush  = fl_c[1] & ~rst;
  assign idex_flush  = fl_c[0] & ~rst;
  assign stall_cnt   = stall_cnt_reg;
  assign timeout_err = timeout_err_reg;

endmodule
